// File: rtl/video_pkg.sv
// Shared video definitions: framebuffer defaults, read-tag ownership codes and
// the RGB332 to 8/8/8 colour expansion used by the VRAM read path.
package video_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    localparam logic OWNER_VID = 1'b0;
    localparam logic OWNER_CPU = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bit replication keeps full-scale codes at 0xFF and zero at 0x00.
    function automatic rgb_t expand332(input logic [7:0] d);
        rgb_t c;
        c.r = {d[7:5], d[7:5], d[7:6]};
        c.g = {d[4:2], d[4:2], d[4:3]};
        c.b = {4{d[1:0]}};
        return c;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the video, CPU and VRAM signals around the arbiter; slave is the
// arbiter's view, master is the surrounding system (HDMI block, CPU, VRAM).
interface vram_arbiter_if #(
    parameter int ADDR_W = 17
) ();

    logic              vid_en;
    logic [11:0]       vid_x;
    logic [11:0]       vid_y;
    logic [7:0]        pix_r;
    logic [7:0]        pix_g;
    logic [7:0]        pix_b;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_starve;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  vid_en, vid_x, vid_y,
        output pix_r, pix_g, pix_b,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_rvalid, cpu_starve,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vid_en, vid_x, vid_y,
        input  pix_r, pix_g, pix_b,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_rvalid, cpu_starve,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/vram_read_pipe.sv
// Tracks who owns each issued VRAM read and steers the returning byte either
// to the pixel registers or to the CPU read-data port.
module vram_read_pipe
    import video_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic       clock25,
    input  logic       resetn,
    input  tag_t       i_issue,
    input  logic [7:0] i_memRdata,
    output logic [7:0] o_pixR,
    output logic [7:0] o_pixG,
    output logic [7:0] o_pixB,
    output logic [7:0] o_cpuRdata,
    output logic       o_cpuRvalid
);

    tag_t r_tags [RD_LATENCY+1];
    tag_t w_head;
    rgb_t w_rgb;

    assign w_head = r_tags[RD_LATENCY];
    assign w_rgb  = expand332(i_memRdata);

    // Stage 0 is loaded on the same edge that registers mem_addr, so the last
    // stage lines up with mem_rdata RD_LATENCY edges later.
    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            r_tags[0] <= i_issue;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            o_pixR      <= '0;
            o_pixG      <= '0;
            o_pixB      <= '0;
            o_cpuRdata  <= '0;
            o_cpuRvalid <= 1'b0;
        end else begin
            o_cpuRvalid <= w_head.valid && (w_head.owner == OWNER_CPU);
            if (w_head.valid && (w_head.owner == OWNER_VID)) begin
                o_pixR <= w_rgb.r;
                o_pixG <= w_rgb.g;
                o_pixB <= w_rgb.b;
            end
            if (w_head.valid && (w_head.owner == OWNER_CPU)) begin
                o_cpuRdata <= i_memRdata;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out pixel fetches take any cycle they need,
// the CPU gets every remaining slot.
module vram_arbiter
    import video_pkg::*;
#(
    parameter int WIDTH      = FB_WIDTH,
    parameter int HEIGHT     = FB_HEIGHT,
    parameter int ADDR_W     = 17,
    parameter int RD_LATENCY = 1
) (
    input  logic          clock25,
    input  logic          resetn,
    vram_arbiter_if.slave bus
);

    localparam int STARVE_LIMIT = 2 * WIDTH;
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1);

    generate
        if (WIDTH * HEIGHT > (2 ** ADDR_W)) begin : g_sizeCheck
            $error("vram_arbiter: framebuffer does not fit in ADDR_W");
        end
    endgenerate

    logic [11:0]       r_xPrev;
    logic [11:0]       r_yPrev;
    logic [ADDR_W-1:0] r_lineBase;
    logic [ADDR_W-1:0] r_memAddr;
    logic              r_memWe;
    logic [7:0]        r_memWdata;
    logic              r_cpuAck;
    logic              r_cpuStarve;
    logic [CNT_W-1:0]  r_starveCnt;

    logic              w_vidReq;
    logic              w_cpuGrant;
    logic [ADDR_W-1:0] w_lineBase;
    logic [ADDR_W-1:0] w_vidAddr;
    tag_t              w_issue;

    assign w_vidReq   = bus.vid_en && ({bus.vid_x, bus.vid_y} != {r_xPrev, r_yPrev});
    assign w_cpuGrant = bus.cpu_req && !w_vidReq;

    // Line base advances by one line per y step instead of multiplying y by WIDTH.
    always_comb begin
        w_lineBase = r_lineBase;
        if (bus.vid_y == 12'd0) begin
            w_lineBase = '0;
        end else if (bus.vid_y != r_yPrev) begin
            w_lineBase = r_lineBase + ADDR_W'(WIDTH);
        end
    end

    assign w_vidAddr     = w_lineBase + ADDR_W'(bus.vid_x);
    assign w_issue.valid = w_vidReq || (w_cpuGrant && !bus.cpu_we);
    assign w_issue.owner = w_vidReq ? OWNER_VID : OWNER_CPU;

    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            r_xPrev    <= '1;
            r_yPrev    <= '1;
            r_lineBase <= '0;
            r_memAddr  <= '0;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
            r_cpuAck   <= 1'b0;
        end else begin
            if (bus.vid_en) begin
                r_xPrev    <= bus.vid_x;
                r_yPrev    <= bus.vid_y;
                r_lineBase <= w_lineBase;
            end
            r_cpuAck <= w_cpuGrant;
            r_memWe  <= w_cpuGrant && bus.cpu_we;
            if (w_vidReq) begin
                r_memAddr <= w_vidAddr;
            end else if (w_cpuGrant) begin
                r_memAddr  <= bus.cpu_addr;
                r_memWdata <= bus.cpu_wdata;
            end
        end
    end

    // Starvation flag is sticky until reset so software can see it after the fact.
    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            r_starveCnt <= '0;
            r_cpuStarve <= 1'b0;
        end else if (w_cpuGrant) begin
            r_starveCnt <= '0;
        end else if (bus.cpu_req) begin
            if (r_starveCnt < CNT_W'(STARVE_LIMIT)) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
            if (r_starveCnt >= CNT_W'(STARVE_LIMIT - 1)) begin
                r_cpuStarve <= 1'b1;
            end
        end
    end

    assign bus.mem_addr   = r_memAddr;
    assign bus.mem_we     = r_memWe;
    assign bus.mem_wdata  = r_memWdata;
    assign bus.cpu_ack    = r_cpuAck;
    assign bus.cpu_starve = r_cpuStarve;

    vram_read_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_readPipe (
        .clock25     (clock25),
        .resetn      (resetn),
        .i_issue     (w_issue),
        .i_memRdata  (bus.mem_rdata),
        .o_pixR      (bus.pix_r),
        .o_pixG      (bus.pix_g),
        .o_pixB      (bus.pix_b),
        .o_cpuRdata  (bus.cpu_rdata),
        .o_cpuRvalid (bus.cpu_rvalid)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency VRAM model attached.
module tb_vram_arbiter;

    logic clock25;
    logic resetn;
    int   checksRun;
    int   checksPassed;

    vram_arbiter_if #(.ADDR_W(17)) bus ();

    vram_arbiter dut (
        .clock25 (clock25),
        .resetn  (resetn),
        .bus     (bus)
    );

    logic [7:0] vram [0:(1<<17)-1];

    initial clock25 = 1'b0;
    always #20 clock25 = ~clock25;

    // VRAM model: registered read, write-through on the following edge.
    always @(posedge clock25) begin
        if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= vram[bus.mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksRun++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [11:0] x, input logic [11:0] y,
                                 input logic req, input logic we, input logic [16:0] addr,
                                 input logic [7:0] wd);
        bus.vid_en    = en;
        bus.vid_x     = x;
        bus.vid_y     = y;
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(posedge clock25);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 17'd0, 8'd0);
    endtask

    function automatic logic [31:0] pixWord();
        return {8'd0, bus.pix_r, bus.pix_g, bus.pix_b};
    endfunction

    initial begin
        logic [11:0] xVal;
        checksRun    = 0;
        checksPassed = 0;
        resetn       = 1'b0;
        bus.vid_en   = 1'b0;
        bus.vid_x    = '0;
        bus.vid_y    = '0;
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(posedge clock25);
        #1;
        checkOutput("rst_pix", pixWord(), 32'h0);
        checkOutput("rst_ack", bus.cpu_ack, 32'd0);
        checkOutput("rst_rvalid", bus.cpu_rvalid, 32'd0);
        checkOutput("rst_starve", bus.cpu_starve, 32'd0);
        checkOutput("rst_mem_we", bus.mem_we, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_rdata", bus.cpu_rdata, 32'd0);
        resetn = 1'b1;

        // CPU-only traffic during blanking: write then immediate read-back.
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 17'h10, 8'hE0);
        checkOutput("wr_ack", bus.cpu_ack, 32'd1);
        checkOutput("wr_mem_we", bus.mem_we, 32'd1);
        checkOutput("wr_mem_addr", bus.mem_addr, 32'h10);
        checkOutput("wr_mem_wdata", bus.mem_wdata, 32'hE0);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 17'h10, 8'h00);
        checkOutput("rd_ack", bus.cpu_ack, 32'd1);
        checkOutput("rd_mem_we", bus.mem_we, 32'd0);
        idleCycle();
        checkOutput("rd_rvalid_early", bus.cpu_rvalid, 32'd0);
        checkOutput("idle_ack", bus.cpu_ack, 32'd0);
        idleCycle();
        checkOutput("rd_rvalid", bus.cpu_rvalid, 32'd1);
        checkOutput("rd_rdata", bus.cpu_rdata, 32'hE0);
        idleCycle();
        checkOutput("rd_rvalid_pulse", bus.cpu_rvalid, 32'd0);
        checkOutput("idle_mem_addr_hold", bus.mem_addr, 32'h10);

        // Reset arriving while a CPU read is in flight.
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 17'h10, 8'h00);
        checkOutput("mid_ack", bus.cpu_ack, 32'd1);
        idleCycle();
        resetn = 1'b0;
        #1;
        checkOutput("mid_rst_rdata", bus.cpu_rdata, 32'd0);
        checkOutput("mid_rst_ack", bus.cpu_ack, 32'd0);
        checkOutput("mid_rst_mem_addr", bus.mem_addr, 32'd0);
        idleCycle();
        checkOutput("mid_rst_rvalid", bus.cpu_rvalid, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("post_rst_rvalid", bus.cpu_rvalid, 32'd0);
            checkOutput("post_rst_rdata", bus.cpu_rdata, 32'd0);
        end

        // Preload pixels through the CPU port.
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 17'd0, 8'hE0);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 17'd1, 8'h1C);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 17'd2, 8'h03);
        idleCycle();
        idleCycle();

        // Scan-out with x stepping 0,0,1,1.
        applyStimulus(1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 17'd0, 8'd0);
        checkOutput("scan_addr0", bus.mem_addr, 32'd0);
        applyStimulus(1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 17'd0, 8'd0);
        checkOutput("scan_pix_early", pixWord(), 32'h000000);
        applyStimulus(1'b1, 12'd1, 12'd0, 1'b0, 1'b0, 17'd0, 8'd0);
        checkOutput("scan_pix_red", pixWord(), 32'hFF0000);
        checkOutput("scan_addr1", bus.mem_addr, 32'd1);
        applyStimulus(1'b1, 12'd1, 12'd0, 1'b0, 1'b0, 17'd0, 8'd0);
        checkOutput("scan_pix_hold", pixWord(), 32'hFF0000);
        applyStimulus(1'b1, 12'd1, 12'd0, 1'b0, 1'b0, 17'd0, 8'd0);
        checkOutput("scan_pix_green", pixWord(), 32'h00FF00);

        // Contention: CPU read held while x steps every second cycle.
        for (int k = 0; k < 6; k++) begin
            xVal = 12'(2 + k / 2);
            applyStimulus(1'b1, xVal, 12'd0, 1'b1, 1'b0, 17'h100, 8'd0);
            checkOutput("cont_ack", bus.cpu_ack, (k % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput("cont_addr", bus.mem_addr, (k % 2 == 1) ? 32'h100 : 32'(xVal));
            if (k == 2) checkOutput("cont_pix_blue", pixWord(), 32'h0000FF);
        end

        // Line and frame wrap with x fixed at 5.
        for (int y = 0; y < 240; y++) begin
            applyStimulus(1'b1, 12'd5, 12'(y), 1'b0, 1'b0, 17'd0, 8'd0);
            if (y == 0)   checkOutput("wrap_y0", bus.mem_addr, 32'd5);
            if (y == 1)   checkOutput("wrap_y1", bus.mem_addr, 32'd325);
            if (y == 239) checkOutput("wrap_y239", bus.mem_addr, 32'd76485);
        end
        applyStimulus(1'b1, 12'd5, 12'd0, 1'b0, 1'b0, 17'd0, 8'd0);
        checkOutput("wrap_frame", bus.mem_addr, 32'd5);

        // Starvation: a video request every cycle for 640 cycles.
        resetn = 1'b0;
        idleCycle();
        resetn = 1'b1;
        idleCycle();
        for (int i = 1; i <= 640; i++) begin
            applyStimulus(1'b1, 12'(i % 2), 12'd0, 1'b1, 1'b0, 17'h100, 8'd0);
            if (i == 639) checkOutput("starve_639", bus.cpu_starve, 32'd0);
            if (i == 640) begin
                checkOutput("starve_640", bus.cpu_starve, 32'd1);
                checkOutput("starve_no_ack", bus.cpu_ack, 32'd0);
            end
        end
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 17'h100, 8'd0);
        checkOutput("starve_ack", bus.cpu_ack, 32'd1);
        checkOutput("starve_sticky_ack", bus.cpu_starve, 32'd1);
        idleCycle();
        checkOutput("starve_sticky", bus.cpu_starve, 32'd1);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
